// File: rtl/axil_stats_reader.sv
// AXI4-Lite read master that drains the auto-incrementing stats window and
// forwards each returned word on an AXI4-Stream tagged with its index.
module axil_stats_reader #(
    parameter int          NUM_REGS   = 13,
    parameter logic [31:0] STATS_ADDR = 32'h0000_0020
) (
    input  logic        pcie_clk,
    input  logic        pcie_aresetn,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        slverr,
    output logic [31:0] m_axil_araddr,
    output logic        m_axil_arvalid,
    input  logic        m_axil_arready,
    input  logic [31:0] m_axil_rdata,
    input  logic [1:0]  m_axil_rresp,
    input  logic        m_axil_rvalid,
    output logic        m_axil_rready,
    output logic [31:0] m_axis_tdata,
    output logic [7:0]  m_axis_tuser,
    output logic        m_axis_tlast,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready
);

    localparam logic [7:0] LAST_IDX = 8'(NUM_REGS - 1);

    typedef enum logic [2:0] {
        IDLE,
        AR,
        R,
        OUT,
        FIN
    } state_t;

    state_t     state;
    state_t     state_next;
    logic [7:0] idx;
    logic       ar_hs;
    logic       r_hs;

    assign ar_hs = m_axil_arvalid && m_axil_arready;
    assign r_hs  = m_axil_rvalid && m_axil_rready;

    always_ff @(posedge pcie_clk or negedge pcie_aresetn) begin
        if (!pcie_aresetn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // tvalid is always high in OUT, so tready alone completes the beat.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (start) state_next = AR;
            AR:   if (ar_hs) state_next = R;
            R:    if (r_hs)  state_next = OUT;
            OUT:  if (m_axis_tready) state_next = (idx == LAST_IDX) ? FIN : AR;
            FIN:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // done is raised on the transition into FIN so it is visible while the
    // FSM is still in FIN; a start coinciding with it is therefore ignored.
    always_ff @(posedge pcie_clk or negedge pcie_aresetn) begin
        if (!pcie_aresetn) begin
            busy           <= 1'b0;
            done           <= 1'b0;
            slverr         <= 1'b0;
            idx            <= 8'd0;
            m_axil_araddr  <= 32'd0;
            m_axil_arvalid <= 1'b0;
            m_axil_rready  <= 1'b0;
            m_axis_tdata   <= 32'd0;
            m_axis_tuser   <= 8'd0;
            m_axis_tlast   <= 1'b0;
            m_axis_tvalid  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        busy           <= 1'b1;
                        slverr         <= 1'b0;
                        idx            <= 8'd0;
                        m_axil_araddr  <= STATS_ADDR;
                        m_axil_arvalid <= 1'b1;
                    end
                end
                AR: begin
                    if (ar_hs) begin
                        m_axil_arvalid <= 1'b0;
                        m_axil_rready  <= 1'b1;
                    end
                end
                R: begin
                    if (r_hs) begin
                        m_axil_rready <= 1'b0;
                        m_axis_tdata  <= m_axil_rdata;
                        m_axis_tuser  <= idx;
                        m_axis_tlast  <= (idx == LAST_IDX);
                        m_axis_tvalid <= 1'b1;
                        if (m_axil_rresp != 2'b00) begin
                            slverr <= 1'b1;
                        end
                    end
                end
                OUT: begin
                    if (m_axis_tready) begin
                        m_axis_tvalid <= 1'b0;
                        if (idx == LAST_IDX) begin
                            done <= 1'b1;
                        end else begin
                            idx            <= idx + 8'd1;
                            m_axil_arvalid <= 1'b1;
                        end
                    end
                end
                FIN: begin
                    busy <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axil_stats_reader.sv
// Directed testbench for axil_stats_reader with a delay-configurable
// auto-incrementing AXI4-Lite stats responder.
module tb_axil_stats_reader;

    localparam int NUM_REGS = 13;

    logic        pcie_clk = 1'b0;
    logic        pcie_aresetn;
    logic        start;
    logic        busy;
    logic        done;
    logic        slverr;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;
    logic [31:0] tdata;
    logic [7:0]  tuser;
    logic        tlast;
    logic        tvalid;
    logic        tready;

    int total = 0;
    int bad   = 0;

    int ar_delay = 0;
    int r_delay  = 0;
    int err_idx  = -1;

    axil_stats_reader #(.NUM_REGS(NUM_REGS), .STATS_ADDR(32'h0000_0020)) dut (
        .pcie_clk       (pcie_clk),
        .pcie_aresetn   (pcie_aresetn),
        .start          (start),
        .busy           (busy),
        .done           (done),
        .slverr         (slverr),
        .m_axil_araddr  (araddr),
        .m_axil_arvalid (arvalid),
        .m_axil_arready (arready),
        .m_axil_rdata   (rdata),
        .m_axil_rresp   (rresp),
        .m_axil_rvalid  (rvalid),
        .m_axil_rready  (rready),
        .m_axis_tdata   (tdata),
        .m_axis_tuser   (tuser),
        .m_axis_tlast   (tlast),
        .m_axis_tvalid  (tvalid),
        .m_axis_tready  (tready)
    );

    always #5 pcie_clk = ~pcie_clk;

    // Responder: index advances after every R beat and wraps per snapshot.
    int  resp_idx;
    int  ar_cnt;
    int  r_cnt;
    logic pending;

    always @(posedge pcie_clk or negedge pcie_aresetn) begin
        if (!pcie_aresetn) begin
            arready  <= 1'b0;
            rvalid   <= 1'b0;
            rdata    <= 32'd0;
            rresp    <= 2'b00;
            resp_idx <= 0;
            ar_cnt   <= 0;
            r_cnt    <= 0;
            pending  <= 1'b0;
        end else begin
            if (arvalid && arready) begin
                arready <= 1'b0;
                pending <= 1'b1;
                ar_cnt  <= 0;
                r_cnt   <= 0;
            end else if (arvalid && !pending) begin
                if (ar_cnt >= ar_delay) arready <= 1'b1;
                else ar_cnt <= ar_cnt + 1;
            end
            if (rvalid && rready) begin
                rvalid   <= 1'b0;
                pending  <= 1'b0;
                resp_idx <= (resp_idx == NUM_REGS - 1) ? 0 : resp_idx + 1;
            end else if (pending && !rvalid) begin
                if (r_cnt >= r_delay) begin
                    rvalid <= 1'b1;
                    rdata  <= (resp_idx == err_idx) ? 32'd0 : 32'(32'h100 + resp_idx);
                    rresp  <= (resp_idx == err_idx) ? 2'b10 : 2'b00;
                end else begin
                    r_cnt <= r_cnt + 1;
                end
            end
        end
    end

    // Bus monitor: samples handshakes on the active edge (pre-update values).
    int          ar_count;
    int          ar_bad_addr;
    int          ar_unstable;
    int          t_unstable;
    int          overlap;
    int          done_count;
    int          beat_count;
    logic [31:0] beat_data [32];
    logic [7:0]  beat_user [32];
    logic        beat_last [32];
    logic        prev_ar_wait;
    logic [31:0] prev_addr;
    logic        prev_t_wait;
    logic [31:0] prev_tdata;
    logic [7:0]  prev_tuser;

    always @(posedge pcie_clk) begin
        if (pcie_aresetn) begin
            if (prev_ar_wait && !(arvalid && araddr == prev_addr)) ar_unstable++;
            if (prev_t_wait && !(tvalid && tdata == prev_tdata && tuser == prev_tuser)) t_unstable++;
            if (arvalid && arready) begin
                ar_count++;
                if (araddr !== 32'h20) ar_bad_addr++;
            end
            if ((arvalid && rready) || (rready && tvalid)) overlap++;
            if (tvalid && tready && beat_count < 32) begin
                beat_data[beat_count] = tdata;
                beat_user[beat_count] = tuser;
                beat_last[beat_count] = tlast;
                beat_count++;
            end
            if (done) done_count++;
            prev_ar_wait = arvalid && !arready;
            prev_addr    = araddr;
            prev_t_wait  = tvalid && !tready;
            prev_tdata   = tdata;
            prev_tuser   = tuser;
        end else begin
            prev_ar_wait = 1'b0;
            prev_t_wait  = 1'b0;
        end
    end

    task automatic clear_counts();
        ar_count    = 0;
        ar_bad_addr = 0;
        ar_unstable = 0;
        t_unstable  = 0;
        overlap     = 0;
        done_count  = 0;
        beat_count  = 0;
    endtask

    task automatic pulse_start();
        @(negedge pcie_clk);
        start = 1'b1;
        @(negedge pcie_clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < budget; c++) begin
            @(negedge pcie_clk);
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        pcie_aresetn = 1'b0;
        start        = 1'b0;
        tready       = 1'b1;
        repeat (3) @(negedge pcie_clk);
        total++;
        if ({arvalid, rready, tvalid, tlast, busy, done, slverr} !== 7'b0) begin
            bad++;
            $display("[TB] FAIL reset_ctrl: got arv=%b rr=%b tv=%b tl=%b busy=%b done=%b err=%b want all 0",
                     arvalid, rready, tvalid, tlast, busy, done, slverr);
        end
        total++;
        if (tdata !== 32'd0 || tuser !== 8'd0) begin
            bad++;
            $display("[TB] FAIL reset_data: got tdata=%h tuser=%0d want 0/0", tdata, tuser);
        end
        pcie_aresetn = 1'b1;
        repeat (2) @(negedge pcie_clk);
    endtask

    task automatic test_basic();
        bit ok;
        ar_delay = 0; r_delay = 0; err_idx = -1; tready = 1'b1;
        clear_counts();
        pulse_start();
        total++;
        if (busy !== 1'b1) begin
            bad++;
            $display("[TB] FAIL basic_busy: got %b want 1", busy);
        end
        wait_done(500, ok);
        total++;
        if (!ok) begin
            bad++;
            $display("[TB] FAIL basic_done_timeout: got no done want done within 500 cycles");
        end
        repeat (4) @(negedge pcie_clk);
        total++;
        if (beat_count !== 13 || ar_count !== 13 || ar_bad_addr !== 0 || done_count !== 1) begin
            bad++;
            $display("[TB] FAIL basic_counts: got beats=%0d ar=%0d badaddr=%0d done=%0d want 13/13/0/1",
                     beat_count, ar_count, ar_bad_addr, done_count);
        end
        for (int i = 0; i < 13; i++) begin
            total++;
            if (beat_data[i] !== 32'(32'h100 + i) || beat_user[i] !== 8'(i) || beat_last[i] !== (i == 12)) begin
                bad++;
                $display("[TB] FAIL basic_beat%0d: got %h/%0d/%b want %h/%0d/%b",
                         i, beat_data[i], beat_user[i], beat_last[i], 32'(32'h100 + i), i, (i == 12));
            end
        end
        total++;
        if (slverr !== 1'b0 || busy !== 1'b0 || overlap !== 0) begin
            bad++;
            $display("[TB] FAIL basic_final: got err=%b busy=%b overlap=%0d want 0/0/0", slverr, busy, overlap);
        end
    endtask

    task automatic test_backpressure();
        bit ok;
        ar_delay = 0; r_delay = 0; err_idx = -1; tready = 1'b0;
        clear_counts();
        pulse_start();
        for (int i = 0; i < 13; i++) begin
            ok = 1'b0;
            for (int c = 0; c < 100; c++) begin
                if (tvalid) begin
                    ok = 1'b1;
                    break;
                end
                @(negedge pcie_clk);
            end
            total++;
            if (!ok) begin
                bad++;
                $display("[TB] FAIL bp_beat%0d_timeout: got no tvalid want tvalid within 100 cycles", i);
                break;
            end
            if (i == 3) begin
                for (int c = 0; c < 20; c++) begin
                    total++;
                    if (tdata !== 32'h103 || tuser !== 8'd3 || rready !== 1'b0 || arvalid !== 1'b0) begin
                        bad++;
                        $display("[TB] FAIL bp_hold_c%0d: got tdata=%h tuser=%0d rr=%b arv=%b want 103/3/0/0",
                                 c, tdata, tuser, rready, arvalid);
                    end
                    @(negedge pcie_clk);
                end
            end
            tready = 1'b1;
            @(negedge pcie_clk);
            tready = 1'b0;
        end
        wait_done(50, ok);
        tready = 1'b1;
        repeat (2) @(negedge pcie_clk);
        total++;
        if (beat_count !== 13 || t_unstable !== 0 || done_count !== 1) begin
            bad++;
            $display("[TB] FAIL bp_counts: got beats=%0d unstable=%0d done=%0d want 13/0/1",
                     beat_count, t_unstable, done_count);
        end
        for (int i = 0; i < 13; i++) begin
            total++;
            if (beat_data[i] !== 32'(32'h100 + i) || beat_user[i] !== 8'(i)) begin
                bad++;
                $display("[TB] FAIL bp_beat%0d: got %h/%0d want %h/%0d",
                         i, beat_data[i], beat_user[i], 32'(32'h100 + i), i);
            end
        end
    endtask

    task automatic test_slow_slave();
        bit ok;
        ar_delay = 5; r_delay = 7; err_idx = -1; tready = 1'b1;
        clear_counts();
        pulse_start();
        wait_done(1000, ok);
        total++;
        if (!ok) begin
            bad++;
            $display("[TB] FAIL slow_done_timeout: got no done want done within 1000 cycles");
        end
        repeat (2) @(negedge pcie_clk);
        total++;
        if (ar_unstable !== 0 || ar_count !== 13 || ar_bad_addr !== 0 || beat_count !== 13) begin
            bad++;
            $display("[TB] FAIL slow_counts: got unstable=%0d ar=%0d badaddr=%0d beats=%0d want 0/13/0/13",
                     ar_unstable, ar_count, ar_bad_addr, beat_count);
        end
        for (int i = 0; i < 13; i++) begin
            total++;
            if (beat_data[i] !== 32'(32'h100 + i) || beat_user[i] !== 8'(i)) begin
                bad++;
                $display("[TB] FAIL slow_beat%0d: got %h/%0d want %h/%0d",
                         i, beat_data[i], beat_user[i], 32'(32'h100 + i), i);
            end
        end
    endtask

    task automatic test_slverr();
        bit ok;
        ar_delay = 0; r_delay = 0; err_idx = 12; tready = 1'b1;
        clear_counts();
        pulse_start();
        wait_done(500, ok);
        repeat (2) @(negedge pcie_clk);
        total++;
        if (!ok || beat_count !== 13) begin
            bad++;
            $display("[TB] FAIL slverr_beats: got done=%b beats=%0d want 1/13", ok, beat_count);
        end
        total++;
        if (beat_data[12] !== 32'd0 || beat_user[12] !== 8'd12 || beat_last[12] !== 1'b1) begin
            bad++;
            $display("[TB] FAIL slverr_beat12: got %h/%0d/%b want 0/12/1",
                     beat_data[12], beat_user[12], beat_last[12]);
        end
        total++;
        if (slverr !== 1'b1) begin
            bad++;
            $display("[TB] FAIL slverr_sticky: got %b want 1", slverr);
        end
        err_idx = -1;
        clear_counts();
        pulse_start();
        total++;
        if (slverr !== 1'b0 || busy !== 1'b1) begin
            bad++;
            $display("[TB] FAIL slverr_clear: got err=%b busy=%b want 0/1", slverr, busy);
        end
        wait_done(500, ok);
        repeat (2) @(negedge pcie_clk);
        total++;
        if (!ok || slverr !== 1'b0 || beat_data[0] !== 32'h100) begin
            bad++;
            $display("[TB] FAIL slverr_next: got done=%b err=%b data0=%h want 1/0/100", ok, slverr, beat_data[0]);
        end
    endtask

    task automatic test_start_busy();
        bit ok;
        ar_delay = 0; r_delay = 0; err_idx = -1; tready = 1'b1;
        clear_counts();
        pulse_start();
        for (int c = 0; c < 500 && beat_count < 5; c++) @(negedge pcie_clk);
        pulse_start();
        wait_done(500, ok);
        start = 1'b1;
        @(negedge pcie_clk);
        start = 1'b0;
        total++;
        if (!ok || busy !== 1'b0 || arvalid !== 1'b0) begin
            bad++;
            $display("[TB] FAIL busy_start_at_done: got done=%b busy=%b arv=%b want 1/0/0", ok, busy, arvalid);
        end
        repeat (10) @(negedge pcie_clk);
        total++;
        if (ar_count !== 13 || done_count !== 1 || beat_count !== 13) begin
            bad++;
            $display("[TB] FAIL busy_counts: got ar=%0d done=%0d beats=%0d want 13/1/13",
                     ar_count, done_count, beat_count);
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        ar_delay = 0; r_delay = 10; err_idx = -1; tready = 1'b1;
        clear_counts();
        pulse_start();
        ok = 1'b0;
        for (int c = 0; c < 1000; c++) begin
            @(negedge pcie_clk);
            if (beat_count == 6 && rready) begin
                ok = 1'b1;
                break;
            end
        end
        total++;
        if (!ok) begin
            bad++;
            $display("[TB] FAIL rstmid_reach: got no R at idx 6 want R within 1000 cycles");
        end
        #2 pcie_aresetn = 1'b0;
        #1;
        total++;
        if ({arvalid, rready, tvalid, tlast, busy, done, slverr} !== 7'b0 || tdata !== 32'd0 || tuser !== 8'd0) begin
            bad++;
            $display("[TB] FAIL rstmid_async: got arv=%b rr=%b tv=%b busy=%b tdata=%h tuser=%0d want all 0",
                     arvalid, rready, tvalid, busy, tdata, tuser);
        end
        @(negedge pcie_clk);
        pcie_aresetn = 1'b1;
        r_delay = 0;
        clear_counts();
        pulse_start();
        wait_done(500, ok);
        repeat (2) @(negedge pcie_clk);
        total++;
        if (!ok || beat_count !== 13 || beat_user[0] !== 8'd0 || beat_data[0] !== 32'h100) begin
            bad++;
            $display("[TB] FAIL rstmid_restart: got done=%b beats=%0d user0=%0d data0=%h want 1/13/0/100",
                     ok, beat_count, beat_user[0], beat_data[0]);
        end
    endtask

    initial begin
        clear_counts();
        prev_ar_wait = 1'b0;
        prev_t_wait  = 1'b0;
        test_reset();
        test_basic();
        test_backpressure();
        test_slow_slave();
        test_slverr();
        test_start_busy();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/axil_stats_reader.md
Name: axil_stats_reader

Overview:
- AXI4-Lite master that drains the auto-incrementing statistics window of the DDR/DMA stats register block.
- On a start pulse it issues NUM_REGS back-to-back single reads to one fixed address, where the responder advances its internal index after each read.
- Each returned word is forwarded on an AXI4-Stream with its index and last flag.
- Sits in the pcie_clk domain, ahead of the clock converter, and feeds a host-visible snapshot buffer.

Parameters:
- NUM_REGS, 13, reads per snapshot (1..255).
- STATS_ADDR, 32'h0000_0020, read address of the stats window (register index 1 shifted left 5).

Ports:
- pcie_clk in 1: block clock.
- pcie_aresetn in 1: asynchronous active-low reset.
- start in 1: single-cycle snapshot request.
- busy out 1: high from accepted start until done.
- done out 1: one-cycle pulse after the last word is accepted on the stream.
- slverr out 1: sticky; set if any R beat of the current snapshot had rresp!=OKAY; cleared on an accepted start.
- m_axil_araddr out 32: read address.
- m_axil_arvalid out 1: AR valid.
- m_axil_arready in 1: AR ready.
- m_axil_rdata in 32: read data.
- m_axil_rresp in 2: read response.
- m_axil_rvalid in 1: R valid.
- m_axil_rready out 1: R ready.
- m_axis_tdata out 32: stats word.
- m_axis_tuser out 8: register index 0..NUM_REGS-1.
- m_axis_tlast out 1: high on index NUM_REGS-1.
- m_axis_tvalid out 1: stream valid.
- m_axis_tready in 1: stream ready.

Behaviour:
- Reset (async assert, sync deassert inside the reset tree): arvalid=0, rready=0, tvalid=0, tdata=0, tuser=0, tlast=0, busy=0, done=0, slverr=0, state=IDLE, idx=0.
- Reset mid-snapshot abandons the snapshot. The responder must be reset together with this block; no recovery of outstanding transactions.
- FSM IDLE -> AR -> R -> OUT -> (AR | FIN) -> IDLE.
- IDLE:
  - start=1 -> busy<=1, slverr<=0, idx<=0, araddr<=STATS_ADDR, arvalid<=1, go to AR.
  - start=0 -> stay.
- AR:
  - arvalid held high; araddr held stable until arready.
  - On arvalid&&arready: arvalid<=0, rready<=1, go to R.
- R:
  - On rvalid&&rready: rready<=0, tdata<=rdata, tuser<=idx, tlast<=(idx==NUM_REGS-1), tvalid<=1.
  - If rresp!=2'b00, set slverr<=1. Data is still forwarded.
  - Go to OUT.
- OUT:
  - tdata, tuser and tlast held stable while tvalid&&!tready.
  - On tready: tvalid<=0.
    - If idx==NUM_REGS-1: go to FIN.
    - Else: idx<=idx+1, arvalid<=1, go to AR.
- FIN: done<=1 for exactly one cycle, busy<=0, go to IDLE.
- Ordering and outstanding reads:
  - At most one read outstanding; AR and R are never active in the same cycle.
  - rready is never high while tvalid is high, so no stream buffering is needed and backpressure propagates to the R channel.
- start while busy=1 is ignored (no queueing).
- start in the same cycle as the done pulse is ignored. The new snapshot starts the cycle after IDLE is re-entered, if start is asserted again.
- Minimum latency per word with ready=1 everywhere and a 1-cycle responder: 4 cycles (AR, R, OUT, next AR).
- idx is 8-bit and never wraps, because the FIN transition occurs at NUM_REGS-1.
- rdata is sampled only in the cycle of rvalid&&rready.

Test Plan:
- Basic drain:
  - Stimulus: NUM_REGS=13, responder returns 0x100+index, all ready=1, pulse start.
  - Required: 13 stream beats with tdata 0x100..0x10C, tuser 0..12, tlast only on beat 12; exactly 13 AR handshakes at 0x20; done pulses once; slverr=0.
- Stream backpressure:
  - Stimulus: hold tready=0 for 20 cycles on beat 3.
  - Required: tdata=0x103 and tuser=3 stay stable; rready=0 and arvalid=0 throughout; the sequence resumes with no lost or duplicated word.
- Slow slave:
  - Stimulus: arready delayed 5 cycles, rvalid delayed 7 cycles.
  - Required: araddr and arvalid stable until the handshake; the full 13 words are still delivered in order.
- SLVERR:
  - Stimulus: responder returns rresp=2'b10 with rdata=0 on index 12.
  - Required: the beat is still emitted; slverr=1 after done.
  - Follow-up: a new start clears slverr to 0.
- Start while busy:
  - Stimulus: pulse start at word 5, and again in the same cycle as done.
  - Required: both pulses ignored; exactly 13 AR handshakes in total.
- Async reset mid-snapshot:
  - Stimulus: assert pcie_aresetn=0 while in R at idx=6.
  - Required: all outputs go to their reset values immediately, before the next clock edge.
  - After release and a new start: the output begins at tuser=0.
